// File: rtl/topk_sched.sv
// topk_sched: job sequencer in front of a pipelined top-k core.
// A job is a counted burst of chunks: clear the core, stream the chunks
// through it one per accepted handshake, wait out the core pipeline, then
// hold the captured result until the consumer takes it.
module topk_sched #(
   parameter int DATA_WIDTH    = 32,
   parameter int LOG_INPUT_NUM = 4,
   parameter int PIPE_LAT      = 8,
   parameter int CNT_W         = 16
) (
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic                                        start,
   input  logic [CNT_W-1:0]                            num_chunks,
   input  logic                                        abort,
   input  logic                                        in_valid,
   input  logic [DATA_WIDTH*(2**LOG_INPUT_NUM)-1:0]    in_data,
   output logic                                        in_ready,
   output logic                                        core_clr,
   output logic                                        core_i_valid,
   output logic [DATA_WIDTH*(2**LOG_INPUT_NUM)-1:0]    core_x,
   input  logic [DATA_WIDTH*(2**LOG_INPUT_NUM)-1:0]    core_y,
   output logic                                        res_valid,
   output logic [DATA_WIDTH*(2**LOG_INPUT_NUM)-1:0]    res_data,
   input  logic                                        res_ready,
   output logic                                        busy,
   output logic                                        done,
   output logic                                        err
);

   localparam int CHUNK_W = DATA_WIDTH * (2 ** LOG_INPUT_NUM);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLR   = 3'd1,
      S_FEED  = 3'd2,
      S_DRAIN = 3'd3,
      S_HOLD  = 3'd4
   } state_t;

   state_t               r_state;
   logic [CNT_W-1:0]     r_num;        // chunk count latched at start
   logic [CNT_W-1:0]     r_cnt;        // chunks accepted so far
   logic [7:0]           r_drain;      // remaining core pipeline cycles
   logic                 r_in_ready;
   logic                 r_core_clr;
   logic                 r_core_i_valid;
   logic [CHUNK_W-1:0]   r_core_x;
   logic                 r_res_valid;
   logic [CHUNK_W-1:0]   r_res_data;
   logic                 r_busy;
   logic                 r_done;
   logic                 r_err;

   logic                 w_hs;
   logic                 w_last;
   logic                 w_start_ok;

   // r_in_ready is only ever set while in FEED, so it doubles as the state qualifier.
   assign w_hs       = r_in_ready & in_valid;
   // Compare before incrementing so the counter never needs a value above num_chunks.
   assign w_last     = (r_cnt == (r_num - CNT_W'(1)));
   // A start is refused in the cycle abort is asserted or done is pulsing.
   assign w_start_ok = start & ~abort & ~r_done;

   // Single-process FSM; every output is a register updated alongside the state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= S_IDLE;
         r_num          <= '0;
         r_cnt          <= '0;
         r_drain        <= '0;
         r_in_ready     <= 1'b0;
         r_core_clr     <= 1'b0;
         r_core_i_valid <= 1'b0;
         r_core_x       <= '0;
         r_res_valid    <= 1'b0;
         r_res_data     <= '0;
         r_busy         <= 1'b0;
         r_done         <= 1'b0;
         r_err          <= 1'b0;
      end else begin
         // Pulse outputs default low each cycle.
         r_core_clr     <= 1'b0;
         r_core_i_valid <= 1'b0;
         r_done         <= 1'b0;
         r_err          <= 1'b0;

         if ((r_state != S_IDLE) && abort) begin
            // Abort wins over any handshake or res_ready seen in the same cycle.
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b0;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (w_start_ok) begin
                     if (num_chunks != '0) begin
                        r_num      <= num_chunks;
                        r_cnt      <= '0;
                        r_core_clr <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= S_CLR;
                     end else begin
                        r_err      <= 1'b1;
                     end
                  end
               end

               S_CLR: begin
                  r_in_ready <= 1'b1;
                  r_state    <= S_FEED;
               end

               S_FEED: begin
                  if (w_hs) begin
                     r_core_i_valid <= 1'b1;
                     r_core_x       <= in_data;
                     r_cnt          <= r_cnt + CNT_W'(1);
                     if (w_last) begin
                        // Drop ready on the same edge so no extra chunk slips in.
                        r_in_ready <= 1'b0;
                        r_drain    <= 8'(PIPE_LAT);
                        r_state    <= S_DRAIN;
                     end
                  end
               end

               S_DRAIN: begin
                  // Loaded on the last handshake edge; reaching zero lines the
                  // capture edge up with PIPE_LAT cycles past the last core_i_valid.
                  if (r_drain == 8'd0) begin
                     r_res_data  <= core_y;
                     r_res_valid <= 1'b1;
                     r_state     <= S_HOLD;
                  end else begin
                     r_drain <= r_drain - 8'd1;
                  end
               end

               S_HOLD: begin
                  if (res_ready) begin
                     r_res_valid <= 1'b0;
                     r_done      <= 1'b1;
                     r_busy      <= 1'b0;
                     r_state     <= S_IDLE;
                  end
               end

               default: begin
                  r_in_ready  <= 1'b0;
                  r_res_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_state     <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign in_ready     = r_in_ready;
   assign core_clr     = r_core_clr;
   assign core_i_valid = r_core_i_valid;
   assign core_x       = r_core_x;
   assign res_valid    = r_res_valid;
   assign res_data     = r_res_data;
   assign busy         = r_busy;
   assign done         = r_done;
   assign err          = r_err;

endmodule

// File: tb/tb_topk_sched.sv
// tb_topk_sched: directed per-cycle vector table plus hand-written sequences
// for hold, abort, mid-job reset and a full-range chunk count.
module tb_topk_sched;

   localparam int DW  = 8;
   localparam int LIN = 2;
   localparam int PL  = 8;
   localparam int CW  = 4;
   localparam int CH  = DW * (2 ** LIN);

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           start = 1'b0;
   logic [CW-1:0]  num_chunks = '0;
   logic           abort = 1'b0;
   logic           in_valid = 1'b0;
   logic [CH-1:0]  in_data = '0;
   logic [CH-1:0]  core_y = '0;
   logic           res_ready = 1'b0;
   wire            in_ready, core_clr, core_i_valid, res_valid, busy, done, err;
   wire  [CH-1:0]  core_x, res_data;

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;

   always #5 clk = ~clk;

   topk_sched #(.DATA_WIDTH(DW), .LOG_INPUT_NUM(LIN), .PIPE_LAT(PL), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .start(start), .num_chunks(num_chunks), .abort(abort),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .core_clr(core_clr), .core_i_valid(core_i_valid), .core_x(core_x),
      .core_y(core_y), .res_valid(res_valid), .res_data(res_data),
      .res_ready(res_ready), .busy(busy), .done(done), .err(err)
   );

   localparam logic [31:0] A = 32'h1111_1111;
   localparam logic [31:0] B = 32'h2222_2222;
   localparam logic [31:0] C = 32'h3333_3333;
   localparam logic [31:0] D = 32'h4444_4444;
   localparam logic [31:0] E = 32'hE0E0_E0E0;
   localparam logic [31:0] F = 32'hF0F0_F0F0;

   // core_y is unique per cycle so the capture edge is visible in res_data.
   function automatic logic [31:0] Y(input int i);
      return 32'h5A00_0000 + 32'(i);
   endfunction

   function automatic logic [70:0] pk(input logic ir, clr, iv, input logic [31:0] x,
                                      input logic rv, input logic [31:0] rd,
                                      input logic b, dn, er);
      return {ir, clr, iv, x, rv, rd, b, dn, er};
   endfunction

   function automatic logic [70:0] outs();
      return {in_ready, core_clr, core_i_valid, core_x, res_valid, res_data, busy, done, err};
   endfunction

   task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   task automatic step();
      core_y = Y(cyc);
      @(posedge clk);
      #1;
      cyc++;
   endtask

   typedef struct {
      logic        st;
      logic [3:0]  n;
      logic        ab;
      logic        iv;
      logic [31:0] d;
      logic        rr;
      logic [70:0] ex;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic st, input logic [3:0] n, input logic ab, iv,
                      input logic [31:0] d, input logic rr,
                      input logic eir, eclr, eiv, input logic [31:0] ex,
                      input logic erv, input logic [31:0] erd, input logic eb, edn, eer);
      vec_t v;
      v.st = st; v.n = n; v.ab = ab; v.iv = iv; v.d = d; v.rr = rr;
      v.ex = pk(eir, eclr, eiv, ex, erv, erd, eb, edn, eer);
      tbl.push_back(v);
   endtask

   // One single-chunk job, optionally holding res_ready low for 'hold' cycles.
   task automatic run_one(input logic [31:0] d, input int hold, input string tag);
      int h;
      logic [31:0] yc;
      logic ok;
      start = 1'b1; num_chunks = 4'd1; step(); start = 1'b0;
      check($sformatf("%s_clr", tag), {core_clr, busy, in_ready}, 3'b110);
      step();
      check($sformatf("%s_feed", tag), {core_clr, in_ready}, 2'b01);
      in_valid = 1'b1; in_data = d; h = cyc; step(); in_valid = 1'b0;
      check($sformatf("%s_iv", tag), {core_i_valid, core_x, in_ready}, {1'b1, d, 1'b0});
      ok = 1'b1;
      for (int k = 0; k < PL; k++) begin
         step();
         if (res_valid || core_i_valid || done) ok = 1'b0;
      end
      check($sformatf("%s_drain", tag), ok, 1);
      step();
      yc = Y(h + PL + 1);
      check($sformatf("%s_cap", tag), {res_valid, res_data}, {1'b1, yc});
      ok = 1'b1;
      for (int k = 0; k < hold; k++) begin
         step();
         if (!res_valid || res_data !== yc || done) ok = 1'b0;
      end
      if (hold > 0) check($sformatf("%s_hold", tag), ok, 1);
      res_ready = 1'b1; step(); res_ready = 1'b0;
      check($sformatf("%s_done", tag), {res_valid, done, busy, res_data}, {3'b010, yc});
      step();
      check($sformatf("%s_idle", tag), {done, busy}, 2'b00);
   endtask

   initial begin
      int h;
      logic ok;
      logic [31:0] ex;

      // Vector table: row i inputs are applied for the cycle ending at edge i,
      // expectations are the outputs just after that edge.
      add(1,3,0,0,0,0, 0,1,0,0,0,0,1,0,0);          // 0  start 3 chunks
      add(0,0,0,1,A,0, 1,0,0,0,0,0,1,0,0);          // 1  CLR -> FEED
      add(0,0,0,1,A,0, 1,0,1,A,0,0,1,0,0);          // 2  chunk A
      add(1,2,0,1,B,0, 1,0,1,B,0,0,1,0,0);          // 3  chunk B, start ignored
      add(0,0,0,1,C,0, 0,0,1,C,0,0,1,0,0);          // 4  chunk C, last
      for (int r = 5; r <= 12; r++)
         add(r == 7,0,0,1,D,0, 0,0,0,C,0,0,1,0,0);  // DRAIN, no extra chunk, no err
      add(0,0,0,1,D,0, 0,0,0,C,1,Y(13),1,0,0);      // 13 capture
      add(0,0,0,0,0,0, 0,0,0,C,1,Y(13),1,0,0);      // 14 hold
      add(0,0,0,0,0,1, 0,0,0,C,0,Y(13),0,1,0);      // 15 consume -> done
      add(1,1,0,0,0,0, 0,0,0,C,0,Y(13),0,0,0);      // 16 start during done refused
      add(1,2,0,0,0,0, 0,1,0,C,0,Y(13),1,0,0);      // 17 start 2 chunks
      add(0,0,0,0,0,0, 1,0,0,C,0,Y(13),1,0,0);      // 18 FEED
      add(0,0,0,1,E,0, 1,0,1,E,0,Y(13),1,0,0);      // 19 chunk E
      add(0,0,0,0,F,0, 1,0,0,E,0,Y(13),1,0,0);      // 20 gap
      add(0,0,0,1,F,0, 0,0,1,F,0,Y(13),1,0,0);      // 21 chunk F, ready drops
      for (int r = 22; r <= 29; r++)
         add(0,0,0,r == 22,D,0, 0,0,0,F,0,Y(13),1,0,0);
      add(0,0,0,0,0,1, 0,0,0,F,1,Y(30),1,0,0);      // 30 capture, res_ready already high
      add(0,0,0,0,0,1, 0,0,0,F,0,Y(30),0,1,0);      // 31 single HOLD cycle
      add(0,0,0,0,0,0, 0,0,0,F,0,Y(30),0,0,0);      // 32
      add(1,0,0,0,0,0, 0,0,0,F,0,Y(30),0,0,1);      // 33 zero chunks -> err
      add(0,0,0,0,0,0, 0,0,0,F,0,Y(30),0,0,0);      // 34 err one cycle
      add(1,1,1,0,0,0, 0,0,0,F,0,Y(30),0,0,0);      // 35 start with abort refused
      add(0,0,0,0,0,0, 0,0,0,F,0,Y(30),0,0,0);      // 36

      // Reset values.
      #1 rst = 1'b1;
      #11;
      check("reset", outs(), 0);
      @(posedge clk); #1 rst = 1'b0;

      foreach (tbl[i]) begin
         start = tbl[i].st; num_chunks = tbl[i].n; abort = tbl[i].ab;
         in_valid = tbl[i].iv; in_data = tbl[i].d; res_ready = tbl[i].rr;
         step();
         check($sformatf("row%0d", i), outs(), tbl[i].ex);
      end
      start = 1'b0; abort = 1'b0; in_valid = 1'b0; res_ready = 1'b0;

      // Result held 20 cycles before consumption.
      run_one(32'h0C0F_FEE0, 20, "hold");

      // Abort beats a simultaneous handshake.
      start = 1'b1; num_chunks = 4'd1; step(); start = 1'b0; step();
      in_valid = 1'b1; in_data = A; abort = 1'b1; step(); abort = 1'b0; in_valid = 1'b0;
      check("abhs_idle", {core_i_valid, busy, in_ready, core_clr}, 4'b0000);
      step();
      check("abhs_noiv", {core_i_valid, busy}, 2'b00);

      // Abort during DRAIN.
      start = 1'b1; num_chunks = 4'd2; step(); start = 1'b0; step();
      in_valid = 1'b1; in_data = A; step(); in_data = B; step(); in_valid = 1'b0;
      check("ab_last", {core_i_valid, core_x, in_ready, busy}, {1'b1, B, 1'b0, 1'b1});
      step(); step();
      abort = 1'b1; step(); abort = 1'b0;
      check("ab_idle", {busy, res_valid, in_ready, core_i_valid, done}, 5'b0);
      ok = 1'b1;
      for (int k = 0; k < 12; k++) begin
         step();
         if (res_valid || done || busy) ok = 1'b0;
      end
      check("ab_quiet", ok, 1);
      run_one(32'hBEEF_0001, 0, "abnew");

      // Reset mid-FEED, then a start on the first edge after release.
      start = 1'b1; num_chunks = 4'd3; step(); start = 1'b0; step();
      in_valid = 1'b1; in_data = C; step(); in_valid = 1'b0;
      #3 rst = 1'b1;
      #1;
      check("rst_mid", outs(), 0);
      #2 rst = 1'b0;
      check("rst_rel", {res_valid, done, busy}, 3'b000);
      run_one(32'h0BAD_F00D, 0, "rstnew");

      // Largest chunk count for the counter width, in_valid held high.
      start = 1'b1; num_chunks = 4'hF; step(); start = 1'b0; step();
      check("max_feed", {in_ready, core_clr}, 2'b10);
      ok = 1'b1;
      h = 0;
      for (int k = 0; k < 15; k++) begin
         ex = 32'hD000_0000 + 32'(k);
         in_valid = 1'b1; in_data = ex; h = cyc; step();
         if (!core_i_valid || core_x !== ex || in_ready !== (k < 14)) ok = 1'b0;
      end
      check("max_burst", ok, 1);
      in_data = 32'hDEAD_0000;
      ok = 1'b1;
      for (int k = 0; k < PL; k++) begin
         step();
         if (core_i_valid || in_ready || res_valid) ok = 1'b0;
      end
      check("max_noextra", ok, 1);
      step(); in_valid = 1'b0;
      check("max_cap", {res_valid, res_data, core_x}, {1'b1, Y(h + PL + 1), 32'hD000_000E});
      res_ready = 1'b1; step(); res_ready = 1'b0;
      check("max_done", {res_valid, done, busy}, 3'b010);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/topk_sched.md
TOPK_SCHED -- requirements
Module: topk_sched

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of one element in bits.
REQ-002 Parameter LOG_INPUT_NUM, default 4, log2 of elements per chunk (N = 2**LOG_INPUT_NUM).
REQ-003 Parameter PIPE_LAT, default 8, cycles from the last core i_valid to a final y, range 1..255.
REQ-004 Parameter CNT_W, default 16, width of the chunk counter.
REQ-005 Port clk, input, 1, single clock; all logic on the rising edge.
REQ-006 Port rst, input, 1, asynchronous active-high reset.
REQ-007 Port start, input, 1, job request; sampled in IDLE only.
REQ-008 Port num_chunks, input, CNT_W, chunk count of the job; sampled with start.
REQ-009 Port abort, input, 1, synchronous job cancel.
REQ-010 Port in_valid, input, 1, upstream chunk valid.
REQ-011 Port in_data, input, DATA_WIDTH*N, upstream chunk.
REQ-012 Port in_ready, output, 1, chunk accepted when in_valid && in_ready.
REQ-013 Port core_clr, output, 1, one-cycle clear pulse to the top-k core.
REQ-014 Port core_i_valid, output, 1, drives the core i_valid.
REQ-015 Port core_x, output, DATA_WIDTH*N, drives the core x.
REQ-016 Port core_y, input, DATA_WIDTH*N, core result.
REQ-017 Port res_valid, output, 1, result available.
REQ-018 Port res_data, output, DATA_WIDTH*N, captured result.
REQ-019 Port res_ready, input, 1, result consumed when res_valid && res_ready.
REQ-020 Port busy, output, 1, high in any state except IDLE.
REQ-021 Port done, output, 1, one-cycle pulse on job completion.
REQ-022 Port err, output, 1, one-cycle pulse when start is rejected.

Function
REQ-023 The FSM SHALL have the states IDLE, CLR, FEED, DRAIN and HOLD.
REQ-024 In IDLE, start with num_chunks != 0 SHALL latch num_chunks, zero the chunk counter and go to CLR.
REQ-025 In IDLE, start with num_chunks == 0 SHALL pulse err for one cycle and stay in IDLE.
REQ-026 start outside IDLE SHALL be ignored, with no err.
REQ-027 CLR SHALL last exactly 1 cycle with core_clr=1, then go to FEED.
REQ-028 In FEED, in_ready SHALL be 1; all other states SHALL drive in_ready=0.
REQ-029 Each FEED handshake SHALL, on the next cycle, drive core_i_valid=1 for exactly one cycle with core_x = the accepted in_data, and SHALL increment the counter.
REQ-030 core_x SHALL hold its last value while core_i_valid=0.
REQ-031 Back-to-back handshakes SHALL give one chunk per cycle with no bubbles.
REQ-032 The handshake of chunk number num_chunks SHALL move FEED to DRAIN and load a drain counter with PIPE_LAT.
REQ-033 No chunk SHALL be accepted beyond num_chunks.
REQ-034 DRAIN SHALL decrement the drain counter each cycle, timed so that core_y is captured into res_data exactly PIPE_LAT cycles after the last core_i_valid cycle, with res_valid=1 in the following cycle and the state moving to HOLD.
REQ-035 In HOLD, res_valid and res_data SHALL stay stable until res_ready=1.
REQ-036 On the res_ready cycle, res_valid SHALL clear, done SHALL pulse in the next cycle, and the state SHALL return to IDLE.
REQ-037 res_ready already high on entry to HOLD SHALL complete the job in a single HOLD cycle.
REQ-038 abort in CLR, FEED, DRAIN or HOLD SHALL go to IDLE next cycle, clear res_valid, suppress done, and cancel any pending core_i_valid.
REQ-039 abort SHALL take priority over a simultaneous handshake or res_ready.
REQ-040 abort in IDLE SHALL have no effect.
REQ-041 A start coinciding with abort or done SHALL NOT be accepted in that cycle.
REQ-042 The chunk counter SHALL NOT wrap; num_chunks = 2**CNT_W-1 SHALL be legal.

Reset
REQ-043 rst=1 SHALL asynchronously force IDLE.
REQ-044 During reset, in_ready, core_clr, core_i_valid, res_valid, busy, done and err SHALL all be 0.
REQ-045 During reset, core_x, res_data and all counters SHALL be 0.
REQ-046 Reset asserted mid-job SHALL discard the job, with no done and no res_valid after release.
REQ-047 The first start SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-048 num_chunks=3, in_valid held high -> core_clr in 1 cycle; core_i_valid high on 3 consecutive cycles carrying chunks A, B, C; res_valid 9 cycles after the last core_i_valid (PIPE_LAT=8); done pulses after res_ready.
REQ-049 num_chunks=2, in_valid toggling 1,0,1 -> exactly 2 core_i_valid pulses; the gap is preserved; in_ready drops after the 2nd handshake.
REQ-050 start with num_chunks=0 -> err=1 for 1 cycle; busy stays 0; no core_clr.
REQ-051 res_ready held low 20 cycles in HOLD -> res_data stable and res_valid=1 throughout; done only after res_ready=1.
REQ-052 abort in DRAIN -> IDLE next cycle; res_valid and done never assert; a new start is then accepted normally.
REQ-053 rst pulsed mid-FEED -> all outputs 0 immediately; after release, a fresh num_chunks=1 job completes correctly.
